// File: rtl/dm_batch_loader.sv
// dm_batch_loader: host-side batch sequencer for the core's data memory.
// It streams input bytes into memory, starts the core, waits for completion,
// and then streams the result bytes back out.
//
// state | meaning
// LOAD  | accept input bytes, write them to IN_BASE+cnt
// REQ   | one-cycle start pulse to the core, bus handed to the core
// RUN   | core owns the bus; wait for a fresh rising done
// DRAIN | read results from OUT_BASE+cnt and present them downstream
module dm_batch_loader #(
  parameter int NUM_BYTES = 30,
  parameter int IN_BASE   = 0,
  parameter int OUT_BASE  = 30,
  parameter int AW        = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [7:0]    in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [7:0]    out_data,
  output logic          dm_own,
  output logic          dm_wr_en,
  output logic [AW-1:0] dm_addr,
  output logic [7:0]    dm_wdata,
  input  logic [7:0]    dm_rdata,
  output logic          req,
  input  logic          done,
  output logic          busy
);

  localparam int CW = $clog2(NUM_BYTES) + 1;

  localparam logic [1:0] LOAD  = 2'd0;
  localparam logic [1:0] REQ   = 2'd1;
  localparam logic [1:0] RUN   = 2'd2;
  localparam logic [1:0] DRAIN = 2'd3;

  logic [1:0]    state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          done_armed, done_armed_nxt;
  logic          cnt_last;
  logic [AW-1:0] cnt_off;

  assign cnt_last = (cnt == CW'(NUM_BYTES - 1));
  assign cnt_off  = AW'(cnt);

  // Next-state, byte counter and done-arming decisions.
  always_comb begin
    state_nxt      = state;
    cnt_nxt        = cnt;
    done_armed_nxt = done_armed;
    unique case (state)
      LOAD: begin
        if (in_valid) begin
          if (cnt_last) begin
            cnt_nxt   = '0;
            state_nxt = REQ;
          end else begin
            cnt_nxt = cnt + CW'(1);
          end
        end
      end
      REQ: begin
        done_armed_nxt = 1'b0;
        state_nxt      = RUN;
      end
      RUN: begin
        // A done still high from the previous batch only counts once the
        // core has dropped it at least once.
        if (!done) begin
          done_armed_nxt = 1'b1;
        end
        if (done_armed && done) begin
          state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        if (out_ready) begin
          if (cnt_last) begin
            cnt_nxt   = '0;
            state_nxt = LOAD;
          end else begin
            cnt_nxt = cnt + CW'(1);
          end
        end
      end
      default: state_nxt = LOAD;
    endcase
  end

  // State registers with asynchronous reset back to an empty LOAD.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= LOAD;
      cnt        <= '0;
      done_armed <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      done_armed <= done_armed_nxt;
    end
  end

  // Output decode from state and cnt; the write enable is gated by LOAD so it
  // can never be asserted while the core owns the bus.
  always_comb begin
    in_ready  = (state == LOAD);
    out_valid = (state == DRAIN);
    req       = (state == REQ);
    busy      = (state == REQ) || (state == RUN);
    dm_own    = (state == LOAD) || (state == DRAIN);
    dm_wr_en  = (state == LOAD) && in_valid;
    dm_wdata  = (state == LOAD) ? in_data : 8'd0;
    out_data  = (state == DRAIN) ? dm_rdata : 8'd0;
    dm_addr   = (state == DRAIN) ? (AW'(OUT_BASE) + cnt_off)
                                 : (AW'(IN_BASE) + cnt_off);
  end

endmodule

// File: tb/tb_dm_batch_loader.sv
// Testbench for dm_batch_loader: memory and core models, randomized batches,
// queue-based scoreboard for memory writes and result bytes.
module tb_dm_batch_loader;

  localparam int NB = 30;
  localparam int IB = 0;
  localparam int OB = 30;
  localparam int AW = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid, in_ready, out_valid, out_ready;
  logic          dm_own, dm_wr_en, req, done, busy;
  logic [7:0]    in_data, out_data, dm_wdata, dm_rdata;
  logic [AW-1:0] dm_addr;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [7:0]  mem [256];
  logic [7:0]  batch_in [NB];
  logic        core_commit = 1'b0;
  logic [15:0] wq [$];
  logic [15:0] oq [$];

  int done_rise_cyc = -100;
  int last_wr_cyc   = -100;
  int first_wr_cyc  = 0;
  int exp_req  = 0;
  int req_seen = 0;
  int or_mode  = 0;
  bit full_tput = 1'b0;
  bit chk_load  = 1'b0;

  dm_batch_loader #(
    .NUM_BYTES(NB), .IN_BASE(IB), .OUT_BASE(OB), .AW(AW)
  ) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .dm_own(dm_own), .dm_wr_en(dm_wr_en), .dm_addr(dm_addr),
    .dm_wdata(dm_wdata), .dm_rdata(dm_rdata),
    .req(req), .done(done), .busy(busy)
  );

  always #5 clk = ~clk;

  // cycle counter
  always @(posedge clk) cyc <= cyc + 1;

  // data memory: loader port plus a core that commits its results at once
  assign dm_rdata = mem[dm_addr];
  always @(posedge clk) begin
    if (dm_own && dm_wr_en) mem[dm_addr] <= dm_wdata;
    if (core_commit)
      for (int i = 0; i < NB; i++) mem[8'(OB + i)] <= mem[8'(IB + i)] ^ 8'hA5;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // downstream ready pattern: held, toggling or random
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      case (or_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = !out_ready;
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // monitor: ownership, writes, req pulse, result bytes
  initial begin
    logic [15:0] e;
    bit prev_req = 1'b0;
    bit prev_ov  = 1'b0;
    forever begin
      @(negedge clk);
      chk("own_vs_busy", 32'(dm_own), 32'(!busy));
      chk("wr_without_own", 32'(dm_wr_en && !dm_own), 32'(0));
      if (!reset) begin
        if (chk_load) begin
          chk("back_to_load", 32'(in_ready), 32'(1));
          chk_load = 1'b0;
        end
        if (dm_own && dm_wr_en) begin
          if (wq.size() == 0) chk("unexpected_write", 32'(dm_addr), 32'hFFFF);
          else begin
            e = wq.pop_front();
            chk("wr_addr", 32'(dm_addr), 32'(e[15:8]));
            chk("wr_data", 32'(dm_wdata), 32'(e[7:0]));
            if (e[15:8] == 8'(IB)) first_wr_cyc = cyc;
            else if (full_tput) chk("wr_consecutive", 32'(cyc), 32'(last_wr_cyc + 1));
            last_wr_cyc = cyc;
          end
        end
        if (req) begin
          chk("req_after_last_write", 32'(cyc), 32'(last_wr_cyc + 1));
          chk("req_single_cycle", 32'(prev_req), 32'(0));
          if (full_tput) chk("req_cycle", 32'(cyc - first_wr_cyc + 1), 32'(NB + 1));
          req_seen++;
        end
        if (out_valid && !prev_ov)
          chk("drain_latency", 32'(cyc), 32'(done_rise_cyc + 1));
        if (out_valid && out_ready) begin
          if (oq.size() == 0) chk("unexpected_out", 32'(out_data), 32'hFFFF);
          else begin
            e = oq.pop_front();
            chk("out_addr", 32'(dm_addr), 32'(e[15:8]));
            chk("out_data", 32'(out_data), 32'(e[7:0]));
            if (oq.size() == 0) chk_load = 1'b1;
          end
        end
      end
      prev_req = req && !reset;
      prev_ov  = out_valid && !reset;
    end
  end

  task automatic check_reset;
    chk("rst_in_ready", 32'(in_ready), 32'(1));
    chk("rst_dm_own", 32'(dm_own), 32'(1));
    chk("rst_dm_addr", 32'(dm_addr), 32'(IB));
    chk("rst_req", 32'(req), 32'(0));
    chk("rst_busy", 32'(busy), 32'(0));
    chk("rst_out_valid", 32'(out_valid), 32'(0));
    chk("rst_wr_en", 32'(dm_wr_en), 32'(in_valid));
  endtask

  // send n bytes; a full batch also registers its expected results
  task automatic send_bytes(input int n, input bit gaps, input bit fixed);
    logic [7:0] b;
    int t;
    for (int i = 0; i < n; i++) begin
      if (gaps) begin
        in_valid = 1'b0;
        repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      end
      b = 8'($urandom);
      if (fixed && i == 0) b = 8'h05;
      if (fixed && i == 1) b = 8'h55;
      batch_in[i] = b;
      in_valid = 1'b1;
      in_data  = b;
      wq.push_back({8'(IB + i), b});
      t = 0;
      @(negedge clk);
      while (!in_ready && t < 2000) begin @(negedge clk); t++; end
      if (!in_ready) chk("in_ready_timeout", 32'(0), 32'(1));
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    if (n == NB) begin
      exp_req++;
      for (int i = 0; i < NB; i++) oq.push_back({8'(OB + i), batch_in[i] ^ 8'hA5});
    end
  endtask

  // core: keeps a stale done for 'hold' cycles after req, runs, then commits
  task automatic core_run(input int hold, input int runtime);
    int t = 0;
    while (!req && t < 3000) begin @(posedge clk); #1; t++; end
    chk("req_seen", 32'(req), 32'(1));
    if (!req) return;
    for (int k = 0; k < hold; k++) begin
      @(posedge clk); #1;
      chk("stale_done_ignored", 32'(busy), 32'(1));
    end
    done = 1'b0;
    for (int k = 0; k < runtime; k++) begin
      @(posedge clk); #1;
      chk("run_hold", 32'({busy, out_valid, dm_own}), 32'(3'b100));
    end
    core_commit   = 1'b1;
    done          = 1'b1;
    done_rise_cyc = cyc;
    @(posedge clk); #1;
    core_commit = 1'b0;
  endtask

  task automatic wait_drain;
    int t = 0;
    while ((oq.size() > 0 || chk_load) && t < 3000) begin @(posedge clk); #1; t++; end
    chk("drain_complete", 32'(oq.size()), 32'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_data = 8'd0; done = 1'b0;
    repeat (2) @(posedge clk); #1;
    check_reset();
    in_valid = 1'b1; #1;
    check_reset();
    in_valid = 1'b0; #1;
    reset = 1'b0;
    @(posedge clk); #1;

    // full-throughput load with fixed leading bytes
    or_mode = 0; full_tput = 1'b1;
    send_bytes(NB, 1'b0, 1'b1);
    chk("mem0", 32'(mem[IB]), 32'h05);
    chk("mem1", 32'(mem[IB + 1]), 32'h55);
    core_run(0, 5);
    full_tput = 1'b0;
    wait_drain();

    // stale done: still high from the previous batch
    or_mode = 2;
    send_bytes(NB, 1'b1, 1'b0);
    core_run(3, 10);
    wait_drain();

    // toggling backpressure; stray in_valid while the core runs
    or_mode = 1;
    send_bytes(NB, 1'b1, 1'b0);
    in_valid = 1'b1; in_data = 8'hEE;
    core_run(2, $urandom_range(1, 8));
    in_valid = 1'b0;
    wait_drain();

    // reset mid-load after 12 bytes
    or_mode = 2;
    send_bytes(12, 1'b1, 1'b0);
    chk("partial_writes_seen", 32'(wq.size()), 32'(0));
    reset = 1'b1; #1;
    check_reset();
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    send_bytes(NB, 1'b1, 1'b0);
    core_run(1, 4);
    wait_drain();

    // back-to-back batches
    for (int b = 0; b < 2; b++) begin
      send_bytes(NB, 1'b1, 1'b0);
      core_run($urandom_range(0, 3), $urandom_range(1, 12));
      wait_drain();
    end

    // reset while req is high drops req immediately
    send_bytes(NB, 1'b0, 1'b0);
    chk("req_before_reset", 32'(req), 32'(1));
    reset = 1'b1; #1;
    chk("req_drop_on_reset", 32'(req), 32'(0));
    check_reset();
    exp_req--;
    oq.delete();
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (3) @(posedge clk); #1;

    chk("req_count", 32'(req_seen), 32'(exp_req));
    chk("writes_left", 32'(wq.size()), 32'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
